line_cmd_dispatcher: RTL and testbench
======================================

Name: line_cmd_dispatcher

Overview:
Upstream feeder for the line-drawing circuit. It buffers line requests (endpoints plus colour) from the shape/command generator in a small FIFO. It then issues them one at a time to the line drawer using that block's level start/done handshake, holding operands stable for the full draw. It decouples the command producer from the variable per-line draw time.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
CNT_W, 16, width of the lines_drawn counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
resetn  input  1  asynchronous active-low reset.
cmd_valid  input  1  producer offers a command this cycle.
cmd_ready  output  1  FIFO can accept; a push occurs when cmd_valid && cmd_ready at the clock edge.
cmd_x0  input  9  line start x.
cmd_y0  input  8  line start y.
cmd_x1  input  9  line end x.
cmd_y1  input  8  line end y.
cmd_colour  input  3  line colour.
lda_start  output  1  start level to the line drawer.
lda_x0  output  9  registered operand to the line drawer.
lda_y0  output  8  registered operand to the line drawer.
lda_x1  output  9  registered operand to the line drawer.
lda_y1  output  8  registered operand to the line drawer.
lda_colour  output  3  registered operand to the line drawer.
lda_done  input  1  line drawer has finished the current line; stays high until start drops.
lda_ready  input  1  line drawer is in its reset/idle state.
busy  output  1  FIFO non-empty or FSM not in IDLE.
fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
lines_drawn  output  CNT_W  count of completed lines; wraps modulo 2^CNT_W.

Behaviour:
- Reset (resetn=0, asynchronous): FIFO emptied, fifo_count=0, state=IDLE, lda_start=0, all lda_* operands=0, lines_drawn=0, busy=0. cmd_ready stays 0 while resetn=0 and goes to 1 on the first clock after release.
- cmd_ready = (fifo_count != DEPTH). A push is refused when full, even if a pop occurs in the same cycle.
- When not full, a simultaneous push and pop in the same cycle both take effect and fifo_count is unchanged.
- Commands leave the FIFO in push order. A push while cmd_ready=0 is ignored and the command is lost; the producer must hold it.
- FSM states: IDLE, DRAW, RELEASE.
  - IDLE: if FIFO non-empty && lda_ready=1 && lda_done=0, then load lda_* from the FIFO head, pop, set lda_start=1, and go to DRAW. Otherwise stay in IDLE.
  - DRAW: hold lda_start=1 and keep operands stable. On lda_done=1, set lda_start=0, increment lines_drawn, and go to RELEASE.
  - RELEASE: wait for lda_done=0, then go to IDLE. Operands stay held until the next launch.
- Latency: command pushed at edge k into an empty FIFO with the drawer idle gives lda_start=1 after edge k+1.
- Back-to-back: the next lda_start rises no earlier than 1 cycle after lda_done falls.
- lda_done=1 observed in IDLE (spurious): no launch, no count change; wait until it is low.
- Degenerate line (x0=x1, y0=y1): passed through unchanged. The dispatcher performs no geometry checks.
- lines_drawn wraps from 2^CNT_W-1 to 0.
- Reset mid-draw: lda_start drops asynchronously and queued commands are discarded.

Decomposition:
- Shared package lda_pkg:
  - width constants X_W=9, Y_W=8, C_W=3.
  - packed struct line_cmd_t {x0, y0, x1, y1, colour} (37 bits).
  - enum disp_state_t {IDLE, DRAW, RELEASE}.
- Sub-module line_cmd_fifo:
  - parameterised synchronous FIFO of line_cmd_t.
  - count-based full/empty.
  - asynchronous active-low reset.
- Top level: the FSM, operand registers and counter.

Test Plan:
- Reset then single push (10,20)->(100,200), colour 3:
  - lda_start=1 two edges after push, operands match.
  - model lda_done after 50 cycles.
  - lda_start falls next edge, lines_drawn=1.
- Push 8 commands with the drawer held busy (lda_ready=0): cmd_ready=0 after the 8th, fifo_count=8, and a 9th push is refused.
- Release the drawer and run all 8: launches occur in push order, lines_drawn=8, busy=0, fifo_count=0.
- Full FIFO, pop and push in the same cycle: push refused, fifo_count 8->7. Then push and pop with count 3: count stays 3 and order is preserved.
- Hold lda_done=1 for 5 cycles after the drop of lda_start: no new launch until lda_done=0, and next lda_start rises 1 cycle later.
- Assert resetn=0 mid-DRAW with 4 queued: lda_start=0 immediately, fifo_count=0, lines_drawn=0, and no launch after release until a new push.

Source files
------------

// File: rtl/lda_pkg.sv
// Shared types for the line-drawer command path: operand widths, the queued
// command record and the dispatcher state encoding.
package lda_pkg;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    typedef struct packed {
        logic [X_W-1:0] x0;
        logic [Y_W-1:0] y0;
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y1;
        logic [C_W-1:0] colour;
    } line_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAW    = 2'd1,
        RELEASE = 2'd2
    } disp_state_t;

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous FIFO of line commands with occupancy-count based full/empty.
// The head entry is presented combinationally so a pop can load it in the same cycle.
module line_cmd_fifo
    import lda_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  line_cmd_t              push_data,
    input  logic                   pop,
    output line_cmd_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    line_cmd_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/line_cmd_dispatcher.sv
// Line command dispatcher: queues line requests and issues them one at a time
// to the line drawer over its level start/done handshake.
module line_cmd_dispatcher
    import lda_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [X_W-1:0]         cmd_x0,
    input  logic [Y_W-1:0]         cmd_y0,
    input  logic [X_W-1:0]         cmd_x1,
    input  logic [Y_W-1:0]         cmd_y1,
    input  logic [C_W-1:0]         cmd_colour,
    output logic                   lda_start,
    output logic [X_W-1:0]         lda_x0,
    output logic [Y_W-1:0]         lda_y0,
    output logic [X_W-1:0]         lda_x1,
    output logic [Y_W-1:0]         lda_y1,
    output logic [C_W-1:0]         lda_colour,
    input  logic                   lda_done,
    input  logic                   lda_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]       lines_drawn
);

    // state   | meaning
    // IDLE    | waiting for a queued command and an idle drawer with done low
    // DRAW    | start held high, operands frozen, waiting for done
    // RELEASE | start dropped, waiting for the drawer to lower done

    disp_state_t state;
    disp_state_t state_nxt;
    line_cmd_t   cmd_in;
    line_cmd_t   head;
    line_cmd_t   ops;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        load;
    logic        count_inc;
    logic        ready_en;

    assign cmd_in    = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour};
    // ready_en keeps cmd_ready low through reset even though the FIFO is empty.
    assign cmd_ready = ready_en && !fifo_full;

    line_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (cmd_valid && cmd_ready),
        .push_data (cmd_in),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        count_inc = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && lda_ready && !lda_done) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (lda_done) begin
                    count_inc = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!lda_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            ops         <= '0;
            lines_drawn <= '0;
            ready_en    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            if (load) begin
                ops <= head;
            end
            if (count_inc) begin
                lines_drawn <= lines_drawn + 1'b1;
            end
        end
    end

    // Start is a pure decode of DRAW so an async reset drops it immediately.
    assign lda_start  = (state == DRAW);
    assign lda_x0     = ops.x0;
    assign lda_y0     = ops.y0;
    assign lda_x1     = ops.x1;
    assign lda_y1     = ops.y1;
    assign lda_colour = ops.colour;
    assign busy       = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_line_cmd_dispatcher.sv
// Bench for line_cmd_dispatcher: behavioural line drawer, launch scoreboard,
// a table-driven fill phase and hand-written handshake/reset sequences.
module tb_line_cmd_dispatcher;
    import lda_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [X_W-1:0]   cmd_x0;
    logic [Y_W-1:0]   cmd_y0;
    logic [X_W-1:0]   cmd_x1;
    logic [Y_W-1:0]   cmd_y1;
    logic [C_W-1:0]   cmd_colour;
    logic             lda_start;
    logic [X_W-1:0]   lda_x0;
    logic [Y_W-1:0]   lda_y0;
    logic [X_W-1:0]   lda_x1;
    logic [Y_W-1:0]   lda_y1;
    logic [C_W-1:0]   lda_colour;
    logic             lda_done;
    logic             lda_ready;
    logic             busy;
    logic [3:0]       fifo_count;
    logic [CNT_W-1:0] lines_drawn;

    line_cmd_dispatcher #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_y0      (cmd_y0),
        .cmd_x1      (cmd_x1),
        .cmd_y1      (cmd_y1),
        .cmd_colour  (cmd_colour),
        .lda_start   (lda_start),
        .lda_x0      (lda_x0),
        .lda_y0      (lda_y0),
        .lda_x1      (lda_x1),
        .lda_y1      (lda_y1),
        .lda_colour  (lda_colour),
        .lda_done    (lda_done),
        .lda_ready   (lda_ready),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .lines_drawn (lines_drawn)
    );

    always #5 clk = ~clk;

    typedef struct {
        line_cmd_t  cmd;
        logic       exp_ready;
        logic [3:0] exp_count;
    } vec_t;

    vec_t             fill_tab [9];
    line_cmd_t        sb [$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_lines;
    bit               auto_drw;
    bit               done_val;
    int               draw_len;
    int               done_hold;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input line_cmd_t c);
        cmd_x0     = c.x0;
        cmd_y0     = c.y0;
        cmd_x1     = c.x1;
        cmd_y1     = c.y1;
        cmd_colour = c.colour;
    endtask

    task automatic push_cmd(input line_cmd_t c, input logic exp_acc, input string nm);
        @(negedge clk);
        drive(c);
        cmd_valid = 1'b1;
        chk({nm, "_ready"}, 64'(cmd_ready), 64'(exp_acc));
        if (exp_acc) sb.push_back(c);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input logic v, input int bound, input string nm, output int n);
        n = bound;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (lda_start === v) begin
                n = i;
                break;
            end
        end
        chk(nm, 64'(lda_start), 64'(v));
    endtask

    task automatic wait_quiet(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = !lda_start && !lda_done;
        end
        chk(nm, 64'(ok), 64'd1);
    endtask

    task automatic wait_not_busy(input int bound, input string nm);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(nm, 64'(busy), 64'd0);
    endtask

    // Launch exactly one command by pulsing lda_ready while the dispatcher is idle,
    // optionally offering a push in the same cycle as the pop.
    task automatic launch_one(input bit do_push, input line_cmd_t c, input logic exp_acc,
                              input string nm);
        wait_quiet({nm, "_quiet"});
        @(negedge clk);
        lda_ready = 1'b1;
        if (do_push) begin
            drive(c);
            cmd_valid = 1'b1;
            chk({nm, "_ready"}, 64'(cmd_ready), 64'(exp_acc));
            if (exp_acc) sb.push_back(c);
        end
        @(posedge clk);
        #1;
        lda_ready = 1'b0;
        cmd_valid = 1'b0;
        chk({nm, "_start"}, 64'(lda_start), 64'd1);
    endtask

    // Behavioural line drawer, updated just after each rising edge.
    initial begin
        int dcnt;
        int hcnt;
        dcnt     = 0;
        hcnt     = 0;
        lda_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!auto_drw) begin
                lda_done = done_val;
                dcnt     = 0;
                hcnt     = 0;
            end else if (lda_done) begin
                if (!lda_start) begin
                    if (hcnt >= done_hold) begin
                        lda_done = 1'b0;
                        hcnt     = 0;
                    end else begin
                        hcnt++;
                    end
                end
            end else if (lda_start) begin
                dcnt++;
                if (dcnt >= draw_len) begin
                    lda_done = 1'b1;
                    dcnt     = 0;
                end
            end
        end
    end

    // Scoreboard: every rising lda_start must present the oldest accepted command.
    initial begin
        logic      prev;
        line_cmd_t exp_c;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (lda_start && !prev) begin
                chk("launch_queued", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_c = sb.pop_front();
                    chk("launch_operands",
                        64'({lda_x0, lda_y0, lda_x1, lda_y1, lda_colour}), 64'(exp_c));
                end
            end
            prev = lda_start;
        end
    end

    initial begin
        line_cmd_t c;
        int        n;
        bit        bad;

        for (int i = 0; i < 9; i++) begin
            fill_tab[i].cmd.x0     = 9'(i * 50 + 1);
            fill_tab[i].cmd.y0     = 8'(i * 20 + 2);
            fill_tab[i].cmd.x1     = 9'(300 - i * 30);
            fill_tab[i].cmd.y1     = 8'(i * 9 + 5);
            fill_tab[i].cmd.colour = 3'(i);
            fill_tab[i].exp_ready  = (i < DEPTH);
            fill_tab[i].exp_count  = 4'((i < DEPTH) ? i + 1 : DEPTH);
        end

        resetn    = 1'b0;
        cmd_valid = 1'b0;
        lda_ready = 1'b0;
        auto_drw  = 1'b1;
        done_val  = 1'b0;
        draw_len  = 50;
        done_hold = 0;
        exp_lines = '0;
        drive('0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start", 64'(lda_start), 64'd0);
        chk("rst_ops", 64'({lda_x0, lda_y0, lda_x1, lda_y1, lda_colour}), 64'd0);
        chk("rst_lines", 64'(lines_drawn), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(cmd_ready), 64'd1);

        // Single line: latency, operands, draw length, count
        lda_ready = 1'b1;
        c = {9'd10, 8'd20, 9'd100, 8'd200, 3'd3};
        push_cmd(c, 1'b1, "t1_push");
        chk("t1_no_start_yet", 64'(lda_start), 64'd0);
        chk("t1_count1", 64'(fifo_count), 64'd1);
        @(posedge clk);
        #1;
        chk("t1_start", 64'(lda_start), 64'd1);
        chk("t1_ops", 64'({lda_x0, lda_y0, lda_x1, lda_y1, lda_colour}), 64'(c));
        chk("t1_lines_mid", 64'(lines_drawn), 64'd0);
        wait_start(1'b0, 100, "t1_fall", n);
        chk("t1_draw_cycles", 64'(n), 64'd50);
        exp_lines = exp_lines + 1'b1;
        chk("t1_lines", 64'(lines_drawn), 64'(exp_lines));

        // Fill the FIFO with the drawer not ready
        wait_quiet("t2_quiet");
        lda_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_cmd(fill_tab[i].cmd, fill_tab[i].exp_ready, "t2_push");
            chk("t2_count", 64'(fifo_count), 64'(fill_tab[i].exp_count));
        end
        chk("t2_full_ready", 64'(cmd_ready), 64'd0);
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_no_start", 64'(lda_start), 64'd0);

        // Drain all eight in push order
        draw_len  = 3;
        lda_ready = 1'b1;
        wait_not_busy(400, "t3_drain");
        exp_lines = exp_lines + 4'd8;
        chk("t3_lines", 64'(lines_drawn), 64'(exp_lines));
        chk("t3_count", 64'(fifo_count), 64'd0);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Full FIFO: pop and push in one cycle, push refused
        lda_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_cmd(fill_tab[7 - i].cmd, 1'b1, "t4_fill");
        chk("t4_count8", 64'(fifo_count), 64'd8);
        c = {9'd511, 8'd255, 9'd0, 8'd0, 3'd7};
        launch_one(1'b1, c, 1'b0, "t4_full_pp");
        chk("t4_count7", 64'(fifo_count), 64'd7);
        for (int i = 0; i < 4; i++) launch_one(1'b0, c, 1'b0, "t4_pop");
        chk("t4_count3", 64'(fifo_count), 64'd3);
        c = {9'd123, 8'd45, 9'd67, 8'd89, 3'd6};
        launch_one(1'b1, c, 1'b1, "t4_pp3");
        chk("t4_count_same", 64'(fifo_count), 64'd3);
        lda_ready = 1'b1;
        wait_not_busy(400, "t4_drain");
        exp_lines = exp_lines + 4'd9;
        chk("t4_lines_wrap", 64'(lines_drawn), 64'(exp_lines));
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Done held high after start drops
        done_hold = 5;
        push_cmd(fill_tab[2].cmd, 1'b1, "t5_push_a");
        push_cmd(fill_tab[5].cmd, 1'b1, "t5_push_b");
        wait_start(1'b1, 20, "t5_rise", n);
        wait_start(1'b0, 20, "t5_fall", n);
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (lda_start) bad = 1'b1;
            if (!lda_done) break;
        end
        chk("t5_no_launch_in_hold", 64'(bad), 64'd0);
        chk("t5_done_low", 64'(lda_done), 64'd0);
        chk("t5_start_at_fall", 64'(lda_start), 64'd0);
        @(negedge clk);
        chk("t5_start_plus1", 64'(lda_start), 64'd0);
        @(negedge clk);
        chk("t5_start_plus2", 64'(lda_start), 64'd1);
        wait_not_busy(100, "t5_drain");
        exp_lines = exp_lines + 4'd2;
        chk("t5_lines", 64'(lines_drawn), 64'(exp_lines));
        done_hold = 0;

        // Spurious done while idle, degenerate line passes through unchanged
        wait_quiet("t6_quiet");
        auto_drw = 1'b0;
        done_val = 1'b1;
        repeat (2) @(negedge clk);
        c = {9'd77, 8'd33, 9'd77, 8'd33, 3'd5};
        push_cmd(c, 1'b1, "t6_push");
        repeat (5) @(negedge clk);
        chk("t6_no_launch", 64'(lda_start), 64'd0);
        chk("t6_count", 64'(fifo_count), 64'd1);
        chk("t6_lines", 64'(lines_drawn), 64'(exp_lines));
        done_val = 1'b0;
        wait_start(1'b1, 10, "t6_launch", n);
        auto_drw = 1'b1;
        wait_not_busy(100, "t6_drain");
        exp_lines = exp_lines + 1'b1;
        chk("t6_lines_after", 64'(lines_drawn), 64'(exp_lines));

        // Reset mid-draw with four queued
        lda_ready = 1'b0;
        draw_len  = 1000;
        for (int i = 0; i < 5; i++) push_cmd(fill_tab[i].cmd, 1'b1, "t7_push");
        launch_one(1'b0, c, 1'b0, "t7_launch");
        repeat (3) @(negedge clk);
        chk("t7_drawing", 64'(lda_start), 64'd1);
        chk("t7_queued", 64'(fifo_count), 64'd4);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("t7_start_async", 64'(lda_start), 64'd0);
        chk("t7_count", 64'(fifo_count), 64'd0);
        chk("t7_lines", 64'(lines_drawn), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_ready", 64'(cmd_ready), 64'd0);
        sb.delete();
        auto_drw  = 1'b0;
        done_val  = 1'b0;
        exp_lines = '0;
        @(negedge clk);
        resetn    = 1'b1;
        lda_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("t7_no_relaunch", 64'(lda_start), 64'd0);
        chk("t7_idle_busy", 64'(busy), 64'd0);
        draw_len = 4;
        auto_drw = 1'b1;
        c = {9'd300, 8'd150, 9'd5, 8'd6, 3'd1};
        push_cmd(c, 1'b1, "t7_new_push");
        wait_not_busy(100, "t7_drain");
        exp_lines = exp_lines + 1'b1;
        chk("t7_lines_after", 64'(lines_drawn), 64'(exp_lines));
        chk("t7_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
